// File: rtl/mre_pkg.sv
// Shared definitions for the mean-relative-error accumulator: state encoding,
// fixed-point unit and a width sanity check for the accumulator/divider width.
package mre_pkg;

  localparam int OPW_DEF  = 4;
  localparam int FRAC_DEF = 16;
  localparam int ACCW_DEF = 32;
  localparam int CNTW_DEF = 16;

  localparam logic [ACCW_DEF-1:0] FRAC_ONE = ACCW_DEF'(1) << FRAC_DEF;

  typedef enum logic [2:0] {
    IDLE,
    DIV,
    ACC,
    MEAN,
    DONE
  } state_e;

  // (diff << FRAC) must fit in ACCW bits with one bit of headroom.
  function automatic bit accw_ok(input int accw, input int opw, input int frac);
    return accw >= 2 * opw + frac + 1;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The first bit is
// resolved in the start cycle, so the quotient is ready W cycles after start.
module seq_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quo
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  den_q, den_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [W-1:0]  rem_in, n_in, d_in;
  logic [W:0]    trial;

  // A start while busy restarts the operation; this is how an abort is realised.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rem_d  = rem_q;
    q_d    = q_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    rem_in = start ? '0  : rem_q;
    n_in   = start ? num : q_q;
    d_in   = start ? den : den_q;
    trial  = {rem_in, n_in[W-1]};

    if (start || busy_q) begin
      den_d = d_in;
      if (trial >= {1'b0, d_in}) begin
        rem_d = W'(trial - {1'b0, d_in});
        q_d   = {n_in[W-2:0], 1'b1};
      end else begin
        rem_d = trial[W-1:0];
        q_d   = {n_in[W-2:0], 1'b0};
      end
      cnt_d  = start ? CW'(1) : cnt_q + 1'b1;
      busy_d = (cnt_d != CW'(W));
      done_d = (cnt_d == CW'(W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      q_q    <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rem_q  <= rem_d;
      q_q    <= q_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quo  = q_q;

endmodule

// File: rtl/mre_accumulator.sv
// Error-characterisation stage behind an approximate multiplier: accumulates
// per-sample relative error |approx-exact|/exact and reports the sweep mean.
module mre_accumulator
  import mre_pkg::*;
#(
  parameter int OPW  = OPW_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_a,
  input  logic [OPW-1:0]   in_b,
  input  logic [2*OPW-1:0] in_approx,
  input  logic             in_last,
  input  logic             clr,
  output logic [ACCW-1:0]  err_sum,
  output logic [CNTW-1:0]  sample_cnt,
  output logic [CNTW-1:0]  cnt_ge,
  output logic [CNTW-1:0]  cnt_lt,
  output logic [ACCW-1:0]  mean_err,
  output logic             overflow,
  output logic             done
);

  localparam int PW = 2 * OPW;

  if (!accw_ok(ACCW, OPW, FRAC)) begin : g_bad_accw
    $error("mre_accumulator: ACCW too narrow for OPW/FRAC");
  end

  state_e          state_q, state_d;
  logic            rdy_q, rdy_d;
  logic [PW-1:0]   exact_q, exact_d;
  logic            ge_q, ge_d;
  logic            last_q, last_d;
  logic [ACCW-1:0] err_q, err_d;
  logic [ACCW-1:0] sum_q, sum_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] ge_cnt_q, ge_cnt_d;
  logic [CNTW-1:0] lt_cnt_q, lt_cnt_d;
  logic [ACCW-1:0] mean_q, mean_d;
  logic            ovf_q, ovf_d;

  logic [PW-1:0]   exact_in, diff_in;
  logic            accept;
  logic [ACCW:0]   sum_ext;
  logic            div_start, div_busy, div_done;
  logic [ACCW-1:0] div_num, div_den, div_quo;

  assign exact_in = PW'(in_a) * PW'(in_b);
  assign diff_in  = (in_approx >= exact_in) ? in_approx - exact_in : exact_in - in_approx;
  assign accept   = (state_q == IDLE) && rdy_q && in_valid && !clr;
  assign sum_ext  = {1'b0, sum_q} + {1'b0, err_q};

  always_comb begin
    state_d   = state_q;
    exact_d   = exact_q;
    ge_d      = ge_q;
    last_d    = last_q;
    err_d     = err_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    ge_cnt_d  = ge_cnt_q;
    lt_cnt_d  = lt_cnt_q;
    mean_d    = mean_q;
    ovf_d     = ovf_q;
    div_start = 1'b0;
    div_num   = '0;
    div_den   = '0;
    // Ready is registered so it stays low one cycle past the return to IDLE.
    rdy_d     = (state_q == IDLE) && !accept;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          exact_d = exact_in;
          ge_d    = (in_approx >= exact_in);
          last_d  = in_last;
          if (exact_in != '0) begin
            div_start = 1'b1;
            div_num   = ACCW'(diff_in) << FRAC;
            div_den   = ACCW'(exact_in);
            state_d   = DIV;
          end else begin
            err_d   = '0;
            state_d = ACC;
          end
        end
      end
      DIV: begin
        if (div_done && !div_busy) begin
          err_d   = div_quo;
          state_d = ACC;
        end
      end
      ACC: begin
        if (sum_ext[ACCW]) begin
          sum_d = '1;
          ovf_d = 1'b1;
        end else begin
          sum_d = sum_ext[ACCW-1:0];
        end
        if (cnt_q == '1) ovf_d = 1'b1;
        else             cnt_d = cnt_q + 1'b1;
        if (exact_q != '0) begin
          if (ge_q) begin
            if (ge_cnt_q == '1) ovf_d = 1'b1;
            else                ge_cnt_d = ge_cnt_q + 1'b1;
          end else begin
            if (lt_cnt_q == '1) ovf_d = 1'b1;
            else                lt_cnt_d = lt_cnt_q + 1'b1;
          end
        end
        if (last_q) begin
          div_start = 1'b1;
          div_num   = sum_d;
          div_den   = ACCW'(cnt_d);
          state_d   = MEAN;
        end else begin
          state_d = IDLE;
        end
      end
      MEAN: begin
        if (div_done && !div_busy) begin
          mean_d  = div_quo;
          state_d = DONE;
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase

    if (clr) begin
      state_d   = IDLE;
      rdy_d     = 1'b1;
      exact_d   = '0;
      ge_d      = 1'b0;
      last_d    = 1'b0;
      err_d     = '0;
      sum_d     = '0;
      cnt_d     = '0;
      ge_cnt_d  = '0;
      lt_cnt_d  = '0;
      mean_d    = '0;
      ovf_d     = 1'b0;
      div_start = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b1;
      exact_q  <= '0;
      ge_q     <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      ge_cnt_q <= '0;
      lt_cnt_q <= '0;
      mean_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      exact_q  <= exact_d;
      ge_q     <= ge_d;
      last_q   <= last_d;
      err_q    <= err_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      ge_cnt_q <= ge_cnt_d;
      lt_cnt_q <= lt_cnt_d;
      mean_q   <= mean_d;
      ovf_q    <= ovf_d;
    end
  end

  seq_divider #(.W(ACCW)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  assign in_ready   = rdy_q;
  assign err_sum    = sum_q;
  assign sample_cnt = cnt_q;
  assign cnt_ge     = ge_cnt_q;
  assign cnt_lt     = lt_cnt_q;
  assign mean_err   = mean_q;
  assign overflow   = ovf_q;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_mre_accumulator.sv
// Self-checking bench for mre_accumulator: directed sweeps plus random samples,
// compared against an arithmetic reference model of the error statistics.
module tb_mre_accumulator;
  import mre_pkg::*;

  localparam int OPW  = 4;
  localparam int FRAC = 16;
  localparam int ACCW = 32;
  localparam int CNTW = 16;
  localparam longint SUM_MAX = (longint'(1) << ACCW) - 1;
  localparam longint CNT_MAX = (longint'(1) << CNTW) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   in_a;
  logic [OPW-1:0]   in_b;
  logic [2*OPW-1:0] in_approx;
  logic             in_last;
  logic             clr;
  logic [ACCW-1:0]  err_sum;
  logic [CNTW-1:0]  sample_cnt;
  logic [CNTW-1:0]  cnt_ge;
  logic [CNTW-1:0]  cnt_lt;
  logic [ACCW-1:0]  mean_err;
  logic             overflow;
  logic             done;

  mre_accumulator #(.OPW(OPW), .FRAC(FRAC), .ACCW(ACCW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_approx  (in_approx),
    .in_last    (in_last),
    .clr        (clr),
    .err_sum    (err_sum),
    .sample_cnt (sample_cnt),
    .cnt_ge     (cnt_ge),
    .cnt_lt     (cnt_lt),
    .mean_err   (mean_err),
    .overflow   (overflow),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: statistics of the sweep so far, from the error definition.
  longint m_sum, m_cnt, m_ge, m_lt;
  bit     m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_ge = 0; m_lt = 0; m_ovf = 0;
  endtask

  task automatic model_add(input int a, input int b, input int approx);
    longint exact, diff, err;
    exact = longint'(a) * longint'(b);
    err   = 0;
    if (exact != 0) begin
      diff = (approx > exact) ? approx - exact : exact - approx;
      err  = (diff * longint'(FRAC_ONE)) / exact;
      if (approx >= exact) begin
        if (m_ge == CNT_MAX) m_ovf = 1; else m_ge++;
      end else begin
        if (m_lt == CNT_MAX) m_ovf = 1; else m_lt++;
      end
    end
    m_sum += err;
    if (m_sum > SUM_MAX) begin m_sum = SUM_MAX; m_ovf = 1; end
    if (m_cnt == CNT_MAX) m_ovf = 1; else m_cnt++;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_sum"}, 64'(err_sum), 64'(m_sum));
    check({tag, "_cnt"}, 64'(sample_cnt), 64'(m_cnt));
    check({tag, "_ge"},  64'(cnt_ge), 64'(m_ge));
    check({tag, "_lt"},  64'(cnt_lt), 64'(m_lt));
    check({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
  endtask

  task automatic check_final(input string tag);
    check_stats(tag);
    check({tag, "_done"},  64'(done), 64'd1);
    check({tag, "_mean"},  64'(mean_err), 64'(m_sum / m_cnt));
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sum"},   64'(err_sum), 64'd0);
    check({tag, "_cnt"},   64'(sample_cnt), 64'd0);
    check({tag, "_ge"},    64'(cnt_ge), 64'd0);
    check({tag, "_lt"},    64'(cnt_lt), 64'd0);
    check({tag, "_mean"},  64'(mean_err), 64'd0);
    check({tag, "_ovf"},   64'(overflow), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Called at a negedge. Waits for ready, offers one sample, then measures how
  // long in_ready (or, for the last sample, done) stays low. Inputs are
  // scrambled while the stage is busy to show they are ignored.
  task automatic send(input int a, input int b, input int approx, input bit last);
    int wait_c;
    int low;
    int exp_low;
    wait_c = 0;
    while (!in_ready && wait_c < 300) begin
      @(negedge clk);
      wait_c++;
    end
    if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_a      = OPW'(a);
    in_b      = OPW'(b);
    in_approx = (2*OPW)'(approx);
    in_last   = last;
    model_add(a, b, approx);
    @(negedge clk);
    in_a      = OPW'($urandom);
    in_b      = OPW'($urandom);
    in_approx = (2*OPW)'($urandom);
    in_last   = 1'b0;
    low = 0;
    if (last) begin
      exp_low = (a * b != 0) ? 2 * ACCW + 1 : ACCW + 1;
      while (!done && low < 300) begin
        low++;
        @(negedge clk);
      end
      check("done_latency", 64'(low), 64'(exp_low));
    end else begin
      exp_low = (a * b != 0) ? ACCW + 2 : 2;
      while (!in_ready && low < 300) begin
        low++;
        @(negedge clk);
      end
      check("ready_low", 64'(low), 64'(exp_low));
      check("step_sum", 64'(err_sum), 64'(m_sum));
      check("step_cnt", 64'(sample_cnt), 64'(m_cnt));
    end
    in_valid = 1'b0;
  endtask

  // Offers a sample that will be aborted; the model is not updated.
  task automatic accept_only(input int a, input int b, input int approx);
    in_valid  = 1'b1;
    in_a      = OPW'(a);
    in_b      = OPW'(b);
    in_approx = (2*OPW)'(approx);
    in_last   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_accepted", 64'(in_ready), 64'd0);
  endtask

  task automatic do_clr(input string tag);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    check_zero(tag);
  endtask

  initial begin
    int a, b, ap, nsat;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_approx = '0; in_last = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Exact product: zero error.
    send(3, 5, 15, 1);
    check_final("t1");
    check("t1_mean_const", 64'(mean_err), 64'd0);
    check("t1_ge_const", 64'(cnt_ge), 64'd1);
    do_clr("clr1");

    // Under-approximation, then a zero-exact sample.
    send(3, 5, 13, 0);
    check("t2_err_const", 64'(err_sum), 64'd8738);
    check("t2_lt_const", 64'(cnt_lt), 64'd1);
    send(0, 7, 2, 1);
    check_final("t2");
    check("t2_mean_const", 64'(mean_err), 64'd4369);
    do_clr("clr2");

    // Full operand sweep with exact approximations.
    for (int i = 0; i < 256; i++) send(i >> 4, i & 15, (i >> 4) * (i & 15), i == 255);
    check_final("t3");
    check("t3_cnt_const", 64'(sample_cnt), 64'd256);
    check("t3_ge_const", 64'(cnt_ge), 64'd225);
    do_clr("clr3");

    // Asynchronous reset in the middle of a division.
    accept_only(7, 9, 50);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_sum", 64'(err_sum), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_zero("rst_mid");
    send(2, 3, 7, 1);
    check_final("after_rst");
    do_clr("clr4");

    // Synchronous clear in the middle of a division.
    accept_only(7, 9, 50);
    repeat (10) @(negedge clk);
    do_clr("clr_mid");
    send(5, 5, 20, 1);
    check_final("after_clr");
    do_clr("clr5");

    // Random sweeps.
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 12; k++) begin
        a  = int'($urandom_range(0, 15));
        b  = int'($urandom_range(0, 15));
        ap = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255))
                                         : ((a * b + int'($urandom_range(0, 4)) > 2)
                                            ? a * b + int'($urandom_range(0, 4)) - 2 : 0);
        send(a, b, ap, k == 11);
      end
      check_final("rand");
      do_clr("clr_rand");
    end

    // Error-sum saturation.
    nsat = 0;
    while (!m_ovf && nsat < 400) begin
      send(1, 1, 255, 0);
      nsat++;
    end
    send(1, 1, 255, 0);
    check("sat_sum", 64'(err_sum), 64'(SUM_MAX));
    check("sat_ovf", 64'(overflow), 64'd1);
    send(1, 1, 255, 0);
    check("sat_ovf_sticky", 64'(overflow), 64'd1);
    send(1, 1, 1, 1);
    check_final("sat");
    do_clr("clr_sat");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
